// File: rtl/scard_tx_retry.sv
// scard_tx_retry: ISO 7816-3 character transmitter for the smartcard I/O line.
// Sends start, data, parity and guard time on an open-drain line, samples the
// T=0 error signal after each character and retransmits up to MAX_RETRY times.
module scard_tx_retry #(
    parameter int DATA_BITS   = 8,
    parameter int ETU_WIDTH   = 16,
    parameter int GUARD_WIDTH = 8,
    parameter int MAX_RETRY   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ETU_WIDTH-1:0]   etu_div,
    input  logic [GUARD_WIDTH-1:0] guard_etu,
    input  logic                   parity_odd,
    input  logic                   inverse_conv,
    input  logic                   retry_en,
    input  logic                   tx_start,
    input  logic [DATA_BITS-1:0]   tx_data,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_err,
    output logic [3:0]             retry_count,
    output logic                   io_oe,
    input  logic                   io_in
);

    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam int SUB_W0 = (GUARD_WIDTH > IDX_W) ? GUARD_WIDTH : IDX_W;
    // Sub-counter holds the data bit index, guard ETUs, the 8-ETU stuck-line
    // timeout and the 2-ETU backoff, so it needs at least 3 bits.
    localparam int SUB_W  = (SUB_W0 > 3) ? SUB_W0 : 3;

    typedef enum logic [3:0] {
        IDLE, START, DATA, PARITY, GUARD0, CHECK, GUARD_EXT, ERRWAIT, BACKOFF
    } state_t;

    state_t                 state_q, state_d;
    logic [ETU_WIDTH-1:0]   etu_cnt_q, etu_cnt_d;
    logic [SUB_W-1:0]       sub_q, sub_d;
    logic [3:0]             retry_q, retry_d;
    logic                   io_oe_q, io_oe_d;
    logic [ETU_WIDTH-1:0]   etu_len_q;
    logic [GUARD_WIDTH-1:0] guard_q;
    logic [DATA_BITS-1:0]   word_q, word_in;
    logic                   par_q, inv_q, retry_en_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   io_sync, tick, load, done_c, err_c;

    assign io_sync = sync_q[SYNC_STAGES-1];
    assign tick    = (etu_cnt_q == etu_len_q - ETU_WIDTH'(1));

    // Reorder the character into transmission order so DATA always walks bit 0 upward.
    always_comb begin
        word_in = tx_data;
        if (inverse_conv) begin
            for (int i = 0; i < DATA_BITS; i++) begin
                word_in[i] = tx_data[DATA_BITS-1-i];
            end
        end
    end

    // Frame sequencing: ETU timing, bit/guard counting, error sampling and retry.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        etu_cnt_d = tick ? '0 : etu_cnt_q + ETU_WIDTH'(1);
        sub_d     = sub_q;
        retry_d   = retry_q;
        load      = 1'b0;
        done_c    = 1'b0;
        err_c     = 1'b0;
        case (state_q)
            IDLE: begin
                etu_cnt_d = '0;
                if (tx_start) begin
                    load    = 1'b1;
                    state_d = START;
                    sub_d   = '0;
                    retry_d = '0;
                end
            end
            START: if (tick) begin
                state_d = DATA;
                sub_d   = '0;
            end
            DATA: if (tick) begin
                if (sub_q == SUB_W'(DATA_BITS - 1)) state_d = PARITY;
                else                                sub_d   = sub_q + SUB_W'(1);
            end
            PARITY: if (tick) state_d = GUARD0;
            GUARD0: if (tick) state_d = CHECK;
            CHECK: begin
                // The error signal is sampled once, on the first cycle of CHECK.
                if (retry_en_q && (etu_cnt_q == '0) && !io_sync) begin
                    state_d   = ERRWAIT;
                    etu_cnt_d = '0;
                    sub_d     = '0;
                end else if (tick) begin
                    sub_d = '0;
                    if (guard_q == '0) begin
                        state_d = IDLE;
                        done_c  = 1'b1;
                    end else begin
                        state_d = GUARD_EXT;
                    end
                end
            end
            GUARD_EXT: if (tick) begin
                if (sub_q == SUB_W'(guard_q) - SUB_W'(1)) begin
                    state_d = IDLE;
                    done_c  = 1'b1;
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            ERRWAIT: begin
                if (io_sync) begin
                    // The cycle that sees the line high is the first backoff cycle,
                    // so the next start bit lands exactly 2 ETUs after it.
                    state_d   = BACKOFF;
                    etu_cnt_d = ETU_WIDTH'(1);
                    sub_d     = '0;
                end else if (tick) begin
                    if (sub_q == SUB_W'(7)) begin
                        state_d = IDLE;
                        err_c   = 1'b1;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
            end
            BACKOFF: if (tick) begin
                if (sub_q == '0) begin
                    sub_d = SUB_W'(1);
                end else if (retry_q < 4'(MAX_RETRY)) begin
                    retry_d = retry_q + 4'd1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                    err_c   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line drive for the state about to be entered, so io_oe comes straight from a flop.
    always_comb begin
        case (state_d)
            START:   io_oe_d = 1'b1;
            DATA:    io_oe_d = word_q[sub_d[IDX_W-1:0]] ^ ~inv_q;
            PARITY:  io_oe_d = par_q ^ ~inv_q;
            default: io_oe_d = 1'b0;
        endcase
    end

    // State, timing counters and the registered line driver.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            etu_cnt_q <= '0;
            sub_q     <= '0;
            retry_q   <= '0;
            io_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            etu_cnt_q <= etu_cnt_d;
            sub_q     <= sub_d;
            retry_q   <= retry_d;
            io_oe_q   <= io_oe_d;
        end
    end

    // Character and controls captured at accept; held for all retransmissions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            etu_len_q  <= ETU_WIDTH'(4);
            guard_q    <= '0;
            word_q     <= '0;
            par_q      <= 1'b0;
            inv_q      <= 1'b0;
            retry_en_q <= 1'b0;
        end else if (load) begin
            etu_len_q  <= (etu_div < ETU_WIDTH'(4)) ? ETU_WIDTH'(4) : etu_div;
            guard_q    <= guard_etu;
            word_q     <= word_in;
            par_q      <= (^tx_data) ^ parity_odd;
            inv_q      <= inverse_conv;
            retry_en_q <= retry_en;
        end
    end

    // Synchroniser for the asynchronous pad input; resets to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
    end

    assign tx_busy     = (state_q != IDLE);
    assign tx_done     = done_c;
    assign tx_err      = err_c;
    assign retry_count = retry_q;
    assign io_oe       = io_oe_q;

endmodule

// File: tb/tb_scard_tx_retry.sv
// Testbench for scard_tx_retry: table of clean frames plus hand-written
// error, retry, stuck-line and mid-frame reset sequences.
module tb_scard_tx_retry;

    localparam int SYNC_STAGES = 2;
    localparam int LOG_LEN     = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] etu_div = '0;
    logic [7:0]  guard_etu = '0;
    logic        parity_odd = 1'b0, inverse_conv = 1'b0, retry_en = 1'b0;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_busy, tx_done, tx_err, io_oe;
    logic [3:0]  retry_count;
    logic        io_in = 1'b1;

    scard_tx_retry #(
        .DATA_BITS(8), .ETU_WIDTH(16), .GUARD_WIDTH(8), .MAX_RETRY(3), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .etu_div(etu_div), .guard_etu(guard_etu),
        .parity_odd(parity_odd), .inverse_conv(inverse_conv), .retry_en(retry_en),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_err(tx_err), .retry_count(retry_count), .io_oe(io_oe), .io_in(io_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observation record filled by watch().
    logic oe_log [LOG_LEN];
    int   starts [8];
    int   nstarts, done_at, err_at, done_cnt, err_cnt, busy_cnt, both_cnt;

    typedef struct {
        logic [7:0] data;
        int         etu_in;
        int         etu_eff;
        int         guard;
        bit         odd;
        bit         inv;
        bit         ren;
        int         err_att;
        int         poke;
        logic [9:0] pat;   // io_oe per ETU: [9]=start, [8:1]=data in send order, [0]=parity
        int         busy;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive a request; afterwards scramble every input so latching is exercised.
    task automatic start_frame(input logic [7:0] data, input int e, input int g,
                               input bit odd, input bit inv, input bit ren);
        @(negedge clk);
        tx_data = data; etu_div = 16'(e); guard_etu = 8'(g);
        parity_odd = odd; inverse_conv = inv; retry_en = ren;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_data = ~tx_data; etu_div = etu_div + 16'd3; guard_etu = ~guard_etu;
        parity_odd = ~parity_odd; inverse_conv = ~inverse_conv; retry_en = ~retry_en;
    endtask

    // Sample every cycle from accept+1 (k=1). Acts as the card: pulls io_in low
    // from 10.5 ETU after the start bit for low_len cycles on the first err_att
    // attempts. Ends when busy falls, or at (stop_att, stop_off) if stop_att>0.
    task automatic watch(input string name, input int e, input int limit, input int err_att,
                         input int low_len, input int stop_att, input int stop_off, input int poke_k);
        logic prev_oe = 1'b0;
        bit   seen_busy = 1'b0;
        bit   ended = 1'b0;
        int   last_start = 0;
        int   d;
        nstarts = 0; done_at = -1; err_at = -1;
        done_cnt = 0; err_cnt = 0; busy_cnt = 0; both_cnt = 0;
        for (int k = 1; k <= limit && k < LOG_LEN; k++) begin
            oe_log[k] = io_oe;
            if (io_oe && !prev_oe && (nstarts == 0 || k - last_start >= 11 * e)) begin
                if (nstarts < 8) starts[nstarts] = k;
                nstarts++;
                last_start = k;
            end
            prev_oe = io_oe;
            if (tx_busy) begin busy_cnt++; seen_busy = 1'b1; end
            if (tx_done) begin done_cnt++; done_at = k; end
            if (tx_err)  begin err_cnt++;  err_at = k;  end
            if (tx_done && tx_err) both_cnt++;
            if (stop_att != 0 && nstarts == stop_att && k - last_start == stop_off) begin
                ended = 1'b1;
                break;
            end
            if (stop_att == 0 && seen_busy && !tx_busy) begin
                ended = 1'b1;
                break;
            end
            d = k - last_start;
            io_in = !(nstarts >= 1 && nstarts <= err_att && 2 * d >= 21 * e && 2 * d < 21 * e + 2 * low_len);
            tx_start = (k == poke_k);
            if (k == poke_k) tx_data = ~tx_data;
            @(posedge clk);
            #1;
        end
        io_in = 1'b1;
        tx_start = 1'b0;
        check({name, "_ended"}, ended, 1'b1);
    endtask

    // Cycles whose io_oe differs from pattern, followed by tail released ETUs.
    function automatic int pattern_bad(input int s, input int e, input logic [9:0] pat, input int tail);
        int bad = 0;
        logic exp;
        for (int i = 0; i < (10 + tail) * e; i++) begin
            exp = (i / e < 10) ? pat[9 - i / e] : 1'b0;
            if (s + i >= LOG_LEN || oe_log[s + i] !== exp) bad++;
        end
        return bad;
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h3B, 372, 372, 0, 1'b0, 1'b0, 1'b1, 0,  0,  10'b1_00100011_0, 4464};
        vecs[1] = '{8'h3F, 16,  16,  0, 1'b0, 1'b1, 1'b1, 0,  0,  10'b1_00111111_0, 192};
        vecs[2] = '{8'hA5, 2,   4,   2, 1'b0, 1'b0, 1'b1, 0,  20, 10'b1_01011010_1, 56};
        vecs[3] = '{8'h00, 8,   8,   1, 1'b1, 1'b0, 1'b1, 0,  0,  10'b1_11111111_0, 104};
        vecs[4] = '{8'h80, 5,   5,   0, 1'b1, 1'b1, 1'b1, 0,  0,  10'b1_10000000_0, 60};
        vecs[5] = '{8'hFF, 4,   4,   0, 1'b0, 1'b0, 1'b1, 0,  0,  10'b1_00000000_1, 48};
        vecs[6] = '{8'h3B, 16,  16,  0, 1'b0, 1'b0, 1'b0, 99, 0,  10'b1_00100011_0, 192};

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset_io_oe", io_oe, 1'b0);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        check("reset_err", tx_err, 1'b0);
        check("reset_retry", retry_count, 4'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Clean frames (vector 6 has the error pulse on the line but sampling disabled).
        for (int v = 0; v < 7; v++) begin
            start_frame(vecs[v].data, vecs[v].etu_in, vecs[v].guard, vecs[v].odd, vecs[v].inv, vecs[v].ren);
            watch($sformatf("v%0d", v), vecs[v].etu_eff, 6000, vecs[v].err_att, vecs[v].etu_eff, 0, 0, vecs[v].poke);
            check($sformatf("v%0d_start_k", v), starts[0], 1);
            check($sformatf("v%0d_pattern", v),
                  pattern_bad(1, vecs[v].etu_eff, vecs[v].pat, 2 + vecs[v].guard), 0);
            check($sformatf("v%0d_busy", v), busy_cnt, vecs[v].busy);
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_done_at", v), done_at, vecs[v].busy);
            check($sformatf("v%0d_err_cnt", v), err_cnt, 0);
            check($sformatf("v%0d_both", v), both_cnt, 0);
            check($sformatf("v%0d_retry", v), retry_count, 4'd0);
        end

        // Single error on attempt 1: one retransmission, identical bits, then done.
        start_frame(8'h3B, 16, 0, 1'b0, 1'b0, 1'b1);
        watch("single", 16, 2000, 1, 16, 0, 0, 0);
        check("single_starts", nstarts, 2);
        check("single_gap", starts[1] - (starts[0] + 21 * 16 / 2 + 16), 2 * 16 + SYNC_STAGES);
        check("single_pat0", pattern_bad(starts[0], 16, 10'b1_00100011_0, 2), 0);
        check("single_pat1", pattern_bad(starts[1], 16, 10'b1_00100011_0, 2), 0);
        check("single_done_cnt", done_cnt, 1);
        check("single_done_at", done_at, starts[1] + 12 * 16 - 1);
        check("single_err_cnt", err_cnt, 0);
        check("single_retry", retry_count, 4'd1);

        // Error on every attempt: 4 frames, retries exhausted.
        start_frame(8'h3B, 16, 0, 1'b0, 1'b0, 1'b1);
        watch("persist", 16, 4000, 99, 16, 0, 0, 0);
        check("persist_starts", nstarts, 4);
        check("persist_pat3", pattern_bad(starts[3], 16, 10'b1_00100011_0, 2), 0);
        check("persist_retry", retry_count, 4'd3);
        check("persist_err_cnt", err_cnt, 1);
        check("persist_err_at", err_at, starts[3] + 21 * 16 / 2 + 16 + 1 + 2 * 16);
        check("persist_done_cnt", done_cnt, 0);
        check("persist_both", both_cnt, 0);

        // Line held low for 9 ETUs: abort 8 ETUs after the sample.
        start_frame(8'h3B, 16, 0, 1'b0, 1'b0, 1'b1);
        watch("stuck", 16, 2000, 1, 9 * 16, 0, 0, 0);
        check("stuck_starts", nstarts, 1);
        check("stuck_err_cnt", err_cnt, 1);
        check("stuck_err_at", err_at, starts[0] + 19 * 16);
        check("stuck_done_cnt", done_cnt, 0);
        check("stuck_retry", retry_count, 4'd0);

        // Reset in DATA[3] of the retransmission, then a clean 0xA5 frame.
        start_frame(8'hA5, 16, 0, 1'b0, 1'b0, 1'b1);
        watch("midrst", 16, 2000, 1, 16, 2, 4 * 16 + 8, 0);
        check("midrst_pre_oe", io_oe, 1'b1);
        check("midrst_pre_retry", retry_count, 4'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_io_oe", io_oe, 1'b0);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_retry", retry_count, 4'd0);
        check("midrst_done", tx_done, 1'b0);
        check("midrst_err", tx_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start_frame(8'hA5, 16, 0, 1'b0, 1'b0, 1'b1);
        watch("after_rst", 16, 2000, 0, 16, 0, 0, 0);
        check("after_rst_pattern", pattern_bad(1, 16, 10'b1_01011010_1, 2), 0);
        check("after_rst_busy", busy_cnt, 192);
        check("after_rst_done_cnt", done_cnt, 1);
        check("after_rst_err_cnt", err_cnt, 0);
        check("after_rst_retry", retry_count, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
